fpu_norm_round: RTL and testbench



---
 rtl/fpu_norm_round.sv | 173 +++++++++++++++++
 tb/tb_fpu_norm_round.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_norm_round.sv
// Normalise/round stage for the FPU: leading-zero normalisation, subnormal
// denormalisation, IEEE-754 rounding and binary32 packing over two stalling stages.
module fpu_norm_round #(
  parameter int C_EXP          = 8,
  parameter int C_MANT         = 23,
  parameter int C_EXP_PRENORM  = 10,
  parameter int C_MANT_PRENORM = 48
) (
  input  logic                            Clk_CI,
  input  logic                            Rst_RI,
  input  logic                            Flush_SI,
  input  logic                            In_valid_SI,
  output logic                            In_ready_SO,
  input  logic                            Sign_prenorm_DI,
  input  logic signed [C_EXP_PRENORM-1:0] Exp_prenorm_DI,
  input  logic [C_MANT_PRENORM-1:0]       Mant_prenorm_DI,
  input  logic [2:0]                      RM_SI,
  output logic                            Out_valid_SO,
  input  logic                            Out_ready_SI,
  output logic [C_EXP+C_MANT:0]           Result_DO,
  output logic                            OF_SO,
  output logic                            UF_SO,
  output logic                            Zero_SO,
  output logic                            Inexact_SO
);

  localparam int EW     = C_EXP_PRENORM + 1;
  localparam int MW     = C_MANT_PRENORM;
  localparam int LZW    = $clog2(MW);
  localparam int MAX_SH = C_MANT + 3;
  localparam int SHW    = $clog2(MAX_SH + 1);
  localparam int RW     = C_MANT + 1;
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << C_EXP) - 1);

  logic                 adv1, adv2;
  logic                 s1_valid, s1_sign, s1_sticky, s2_valid;
  logic signed [EW-1:0] s1_exp;
  logic [MW-2:0]        s1_mant;
  logic [2:0]           s1_rm;

  assign adv2         = ~s2_valid | Out_ready_SI;
  assign adv1         = ~s1_valid | adv2;
  assign In_ready_SO  = adv1;
  assign Out_valid_SO = s2_valid;

  logic [MW-1:0]        n_mant, sub_mask;
  logic signed [EW-1:0] exp_ext, n_exp, sub_dist;
  logic [LZW-1:0]       lz;
  logic [SHW-1:0]       sub_sh;
  logic                 n_sticky;

  always_comb begin
    exp_ext = {Exp_prenorm_DI[C_EXP_PRENORM-1], Exp_prenorm_DI};
    lz = '0;
    for (int i = 0; i < MW - 1; i++) begin
      if (Mant_prenorm_DI[i]) lz = LZW'(MW - 2 - i);
    end
    n_sticky = 1'b0;
    if (Mant_prenorm_DI[MW-1]) begin
      n_mant   = Mant_prenorm_DI >> 1;
      n_sticky = Mant_prenorm_DI[0];
      n_exp    = exp_ext + EXP_ONE;
    end else begin
      n_mant = Mant_prenorm_DI << lz;
      n_exp  = exp_ext - $signed({{(EW-LZW){1'b0}}, lz});
    end
    // Past MAX_SH the hidden bit already sits below the guard position.
    sub_dist = EXP_ONE - n_exp;
    sub_sh   = (sub_dist > EW'(MAX_SH)) ? SHW'(MAX_SH) : sub_dist[SHW-1:0];
    sub_mask = ~({MW{1'b1}} << sub_sh);
    if (n_exp < EXP_ONE) begin
      n_sticky = n_sticky | (|(n_mant & sub_mask));
      n_mant   = n_mant >> sub_sh;
      n_exp    = '0;
    end
    if (Mant_prenorm_DI == '0) begin
      n_mant   = '0;
      n_exp    = '0;
      n_sticky = 1'b0;
    end
  end

  logic [RW-1:0]          mant_r;
  logic [RW:0]            sum;
  logic                   g_bit, s_bit, rnd_inexact, inc, to_inf, r_of;
  logic signed [EW-1:0]   r_exp;
  logic [C_MANT-1:0]      r_frac;
  logic [C_EXP+C_MANT:0]  r_result;

  always_comb begin
    mant_r      = s1_mant[2*C_MANT:C_MANT];
    g_bit       = s1_mant[C_MANT-1];
    s_bit       = (|s1_mant[C_MANT-2:0]) | s1_sticky;
    rnd_inexact = g_bit | s_bit;
    case (s1_rm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = s1_sign & rnd_inexact;
      3'b011:  inc = ~s1_sign & rnd_inexact;
      3'b100:  inc = g_bit;
      default: inc = g_bit & (s_bit | mant_r[0]);
    endcase
    sum = {1'b0, mant_r} + {{RW{1'b0}}, inc};
    // A subnormal has no hidden bit, so a carry into it promotes exp field to 1.
    if (s1_exp == '0) begin
      r_exp  = {{(EW-1){1'b0}}, sum[RW-1]};
      r_frac = sum[C_MANT-1:0];
    end else if (sum[RW]) begin
      r_exp  = s1_exp + EXP_ONE;
      r_frac = '0;
    end else begin
      r_exp  = s1_exp;
      r_frac = sum[C_MANT-1:0];
    end
    r_of = (r_exp >= EXP_MAX);
    case (s1_rm)
      3'b001:  to_inf = 1'b0;
      3'b010:  to_inf = s1_sign;
      3'b011:  to_inf = ~s1_sign;
      default: to_inf = 1'b1;
    endcase
    if (!r_of)
      r_result = {s1_sign, r_exp[C_EXP-1:0], r_frac};
    else if (to_inf)
      r_result = {s1_sign, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
    else
      r_result = {s1_sign, {(C_EXP-1){1'b1}}, 1'b0, {C_MANT{1'b1}}};
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_mant    <= '0;
      s1_sticky  <= 1'b0;
      s1_rm      <= '0;
      s2_valid   <= 1'b0;
      Result_DO  <= '0;
      OF_SO      <= 1'b0;
      UF_SO      <= 1'b0;
      Zero_SO    <= 1'b0;
      Inexact_SO <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= In_valid_SI;
        if (In_valid_SI) begin
          s1_sign   <= Sign_prenorm_DI;
          s1_exp    <= n_exp;
          s1_mant   <= n_mant[MW-2:0];
          s1_sticky <= n_sticky;
          s1_rm     <= RM_SI;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          Result_DO  <= r_result;
          OF_SO      <= r_of;
          UF_SO      <= ~r_of & (r_exp == '0) & rnd_inexact;
          Zero_SO    <= (r_result[C_EXP+C_MANT-1:0] == '0);
          Inexact_SO <= rnd_inexact | r_of;
        end
      end
      // Flush wins over any advance; output data is left as-is, only valids drop.
      if (Flush_SI) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_norm_round.sv
// Directed self-checking bench for fpu_norm_round: rounding modes, overflow,
// subnormals, zero, stall/flush handshake and mid-operation reset.
module tb_fpu_norm_round;

  localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100;

  logic        clk, rst, flush, in_valid, in_ready, sign;
  logic [9:0]  exp;
  logic [47:0] mant;
  logic [2:0]  rm;
  logic        out_valid, out_ready, of, uf, zero, inexact;
  logic [31:0] result;
  int          compared, mismatched, waited;

  fpu_norm_round dut (
    .Clk_CI(clk), .Rst_RI(rst), .Flush_SI(flush),
    .In_valid_SI(in_valid), .In_ready_SO(in_ready),
    .Sign_prenorm_DI(sign), .Exp_prenorm_DI(exp), .Mant_prenorm_DI(mant), .RM_SI(rm),
    .Out_valid_SO(out_valid), .Out_ready_SI(out_ready), .Result_DO(result),
    .OF_SO(of), .UF_SO(uf), .Zero_SO(zero), .Inexact_SO(inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Drives one operand at a negedge and returns at the negedge after it is accepted.
  task automatic applyStimulus(input logic sg, input logic [9:0] ex, input logic [47:0] mt,
                               input logic [2:0] mode);
    int n = 0;
    sign = sg; exp = ex; mant = mt; rm = mode; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: observed in_ready 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // flags are {of, uf, zero, inexact}
  task automatic checkOutput(input string tag, input logic [31:0] want_res, input logic [3:0] want_flags);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkField({tag, "/valid"}, {31'd0, out_valid}, 32'd1);
    checkField({tag, "/result"}, result, want_res);
    checkField({tag, "/flags"}, {28'd0, of, uf, zero, inexact}, {28'd0, want_flags});
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sign = 1'b0; exp = '0; mant = '0; rm = RNE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkField("reset/valid", {31'd0, out_valid}, 32'd0);
    checkField("reset/result", result, 32'h0);
    checkField("reset/flags", {28'd0, of, uf, zero, inexact}, 32'd0);
    checkField("reset/ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 10'd127, 48'h8000_0000_0000, RNE);
    checkOutput("one_plus_one", 32'h4000_0000, 4'b0000);
    checkField("latency", waited, 32'd1);
    applyStimulus(1'b0, 10'd127, 48'h0000_0080_0000, RNE);
    checkOutput("cancel", 32'h3400_0000, 4'b0000);
    applyStimulus(1'b0, 10'd127, 48'h4000_00C0_0000, RNE);
    checkOutput("tie_rne", 32'h3F80_0002, 4'b0001);
    applyStimulus(1'b0, 10'd127, 48'h4000_00C0_0000, RTZ);
    checkOutput("tie_rtz", 32'h3F80_0001, 4'b0001);
    applyStimulus(1'b1, 10'd127, 48'h4000_00C0_0000, RDN);
    checkOutput("tie_rdn_neg", 32'hBF80_0002, 4'b0001);
    applyStimulus(1'b0, 10'd127, 48'h4000_00C0_0000, 3'b111);
    checkOutput("tie_rm_other", 32'h3F80_0002, 4'b0001);
    applyStimulus(1'b0, 10'd127, 48'h4000_0040_0000, RNE);
    checkOutput("even_rne", 32'h3F80_0000, 4'b0001);
    applyStimulus(1'b0, 10'd127, 48'h4000_0040_0000, RMM);
    checkOutput("even_rmm", 32'h3F80_0001, 4'b0001);
    applyStimulus(1'b0, 10'd254, 48'h7FFF_FFC0_0000, RNE);
    checkOutput("ovf_rne", 32'h7F80_0000, 4'b1001);
    applyStimulus(1'b0, 10'd254, 48'h7FFF_FFC0_0000, RTZ);
    checkOutput("ovf_rtz", 32'h7F7F_FFFF, 4'b0001);
    applyStimulus(1'b1, 10'd255, 48'h4000_0000_0000, RUP);
    checkOutput("ovf_rup_neg", 32'hFF7F_FFFF, 4'b1001);
    applyStimulus(1'b1, 10'd255, 48'h4000_0000_0000, RDN);
    checkOutput("ovf_rdn_neg", 32'hFF80_0000, 4'b1001);
    applyStimulus(1'b0, -10'sd10, 48'h4000_0000_0000, RNE);
    checkOutput("subn_exact", 32'h0000_1000, 4'b0000);
    applyStimulus(1'b0, -10'sd10, 48'h4000_0000_0001, RNE);
    checkOutput("subn_inexact", 32'h0000_1000, 4'b0101);
    applyStimulus(1'b0, 10'd0, 48'h7FFF_FFC0_0000, RNE);
    checkOutput("subn_to_normal", 32'h0080_0000, 4'b0001);
    applyStimulus(1'b0, -10'sd200, 48'h4000_0000_0000, RNE);
    checkOutput("deep_subn_rne", 32'h0000_0000, 4'b0111);
    applyStimulus(1'b0, -10'sd200, 48'h4000_0000_0000, RUP);
    checkOutput("deep_subn_rup", 32'h0000_0001, 4'b0101);
    applyStimulus(1'b1, 10'd127, 48'h0, RNE);
    checkOutput("neg_zero", 32'h8000_0000, 4'b0010);
    @(negedge clk);

    // Stall: two ops fill the pipe, third is held upstream.
    out_ready = 1'b0;
    sign = 1'b0; exp = 10'd127; mant = 48'h8000_0000_0000; rm = RNE; in_valid = 1'b1;
    checkField("hs/ready_a", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    mant = 48'h0000_0080_0000;
    checkField("hs/ready_b", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    mant = 48'h4000_00C0_0000; rm = RTZ;
    checkField("hs/ready_c", {31'd0, in_ready}, 32'd0);
    checkField("hs/out_a", result, 32'h4000_0000);
    checkField("hs/valid_a", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    checkField("hs/hold_ready", {31'd0, in_ready}, 32'd0);
    checkField("hs/hold_a", result, 32'h4000_0000);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkField("hs/out_b", result, 32'h3400_0000);
    @(negedge clk);
    checkField("hs/out_c", result, 32'h3F80_0001);
    checkField("hs/valid_c", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    checkField("hs/drained", {31'd0, out_valid}, 32'd0);

    // Flush with two in flight and a third operand presented.
    out_ready = 1'b0;
    sign = 1'b0; exp = 10'd127; mant = 48'h8000_0000_0000; rm = RNE; in_valid = 1'b1;
    @(negedge clk);
    mant = 48'h0000_0080_0000;
    @(negedge clk);
    mant = 48'h4000_00C0_0000;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checkField("flush/valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkField("flush/empty", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    checkField("flush/dropped", {31'd0, out_valid}, 32'd0);
    applyStimulus(1'b0, 10'd127, 48'h8000_0000_0000, RNE);
    checkOutput("post_flush", 32'h4000_0000, 4'b0000);
    @(negedge clk);

    // Reset mid-operation clears valid and held result.
    out_ready = 1'b0;
    applyStimulus(1'b0, 10'd254, 48'h7FFF_FFC0_0000, RNE);
    @(negedge clk);
    checkField("rst_mid/valid_before", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkField("rst_mid/valid", {31'd0, out_valid}, 32'd0);
    checkField("rst_mid/result", result, 32'h0);
    checkField("rst_mid/flags", {28'd0, of, uf, zero, inexact}, 32'd0);
    checkField("rst_mid/ready", {31'd0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
